instr_encode: RTL

- Inverse of the instruction decoder. Accepts decoded fields (opcode, func3, func7 bit, Rs1/Rs2/Rd, 32-bit imme) over a valid/ready handshake.
- Packs the fields into a 32-bit RV instruction word, range-checks the immediate, and writes the word into instruction memory at an auto-incrementing address.
- Used by the boot/test loader to build program images in hardware.

---
 rtl/instr_encode.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_encode.sv
// Field-to-instruction encoder: packs decoded RV fields into a 32-bit word and writes it to instruction memory.
// Optional macro ENC_RV64W_EN adds op-imm-32 / op-32 as supported opcodes.
module instr_encode #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic              func7,
    input  logic [4:0]        Rs1,
    input  logic [4:0]        Rs2,
    input  logic [4:0]        Rd,
    input  logic [31:0]       imme,
    input  logic              ptr_rst,
    input  logic              err_clr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              err_imm,
    output logic              err_opcode,
    output logic [15:0]       wr_count
);

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, ERR = 2'd2} state_t;
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t state, state_next;
    fmt_t   fmt;
    logic   accept;

    function automatic fmt_t decode_fmt(input logic [6:0] op);
        fmt_t f;
        case (op)
            7'b0110111, 7'b0010111:             f = FMT_U;
            7'b1101111:                         f = FMT_J;
            7'b1100111, 7'b0000011, 7'b0010011: f = FMT_I;
            7'b1100011:                         f = FMT_B;
            7'b0100011:                         f = FMT_S;
            7'b0110011:                         f = FMT_R;
`ifdef ENC_RV64W_EN
            7'b0011011:                         f = FMT_I;
            7'b0111011:                         f = FMT_R;
`endif
            default:                            f = FMT_BAD;
        endcase
        return f;
    endfunction

    function automatic logic [31:0] encode(input fmt_t f, input logic [6:0] op,
                                           input logic [2:0] f3, input logic f7,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [4:0] rd, input logic [31:0] imm);
        logic [31:0] w;
        case (f)
            FMT_R:   w = {1'b0, f7, 5'b0, rs2, rs1, f3, rd, op};
            FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   w = {imm[31:12], rd, op};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = {imm[11:0], rs1, f3, rd, op};
        endcase
        return w;
    endfunction

    // A field is representable when every discarded upper bit equals the kept sign bit.
    function automatic logic imm_bad(input fmt_t f, input logic [31:0] imm);
        logic bad;
        case (f)
            FMT_I, FMT_S: bad = !((&imm[31:11]) || !(|imm[31:11]));
            FMT_B:        bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            FMT_J:        bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            FMT_U:        bad = |imm[11:0];
            default:      bad = 1'b0;
        endcase
        return bad;
    endfunction

    assign fmt = decode_fmt(opcode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = (fmt == FMT_BAD) ? ERR : WRITE;
                end
            end
            WRITE: begin
                mem_we = 1'b1;
                if (mem_ack) state_next = IDLE;
            end
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr   <= BASE;
            mem_wdata  <= '0;
            err_imm    <= 1'b0;
            err_opcode <= 1'b0;
            wr_count   <= '0;
        end else begin
            if (accept) mem_wdata <= encode(fmt, opcode, func3, func7, Rs1, Rs2, Rd, imme);
            if (state == IDLE && ptr_rst) begin
                mem_addr <= BASE;
            end else if (state == WRITE && mem_ack) begin
                mem_addr <= mem_addr + 1'b1;
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end
            // A newly detected error outranks a same-cycle clear.
            err_imm    <= (err_imm & ~err_clr) | (accept & (fmt != FMT_BAD) & imm_bad(fmt, imme));
            err_opcode <= (err_opcode & ~err_clr) | (accept & (fmt == FMT_BAD));
        end
    end

endmodule
